// File: rtl/block_uart_streamer_pkg.sv
// Shared constants, types and state encoding for the decoded-block UART streamer.
package block_uart_streamer_pkg;

    localparam logic [7:0] SYNC_BYTE       = 8'hA5;
    localparam int         TS_W            = 24;
    localparam int         DATA_W          = 17;
    localparam int         BLOCK_W         = TS_W + DATA_W;
    localparam int         BYTES_PER_BLOCK = 6;
    localparam int         WORD_W          = 8 * BYTES_PER_BLOCK;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [DATA_W-1:0] data;
    } block_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_SEND,
        ST_TRAIL,
        ST_GAP
    } state_t;

    // A block goes on the wire zero-extended to a whole number of bytes.
    function automatic logic [WORD_W-1:0] block_to_word(input block_t b);
        return {{(WORD_W - BLOCK_W){1'b0}}, b};
    endfunction

endpackage

// File: rtl/block_uart_streamer_if.sv
// Decoded-block RAM read port: the streamer is master (drives the index), the RAM is slave.
interface block_uart_streamer_if;
    import block_uart_streamer_pkg::*;

    logic [7:0] avl_blocks_nb;
    block_t     block_wanted;
    logic       data_ready;
    logic [7:0] block_wanted_number;

    modport master (
        input  avl_blocks_nb,
        input  block_wanted,
        input  data_ready,
        output block_wanted_number
    );

    modport slave (
        output avl_blocks_nb,
        output block_wanted,
        output data_ready,
        input  block_wanted_number
    );

endinterface

// File: rtl/block_uart_streamer_tx.sv
// UART 8N1 byte transmitter; ready rises on the last stop-bit cycle so bytes chain with no idle.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 833
) (
    input  logic       clk_96MHz,
    input  logic       rst_n,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    shreg;
    logic          active;
    logic          bit_end;

    assign bit_end    = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign byte_ready = !active || (bit_end && bit_idx == 4'd9);

    // bit_idx: 0 = start, 1..8 = data LSB first, 9 = stop
    always_ff @(posedge clk_96MHz or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '1;
            active  <= 1'b0;
            tx      <= 1'b1;
        end else if (byte_valid && byte_ready) begin
            tx      <= 1'b0;
            shreg   <= {1'b1, byte_data};
            bit_idx <= '0;
            clk_cnt <= '0;
            active  <= 1'b1;
        end else if (active) begin
            if (bit_end) begin
                clk_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                    bit_idx <= bit_idx + 4'd1;
                end
            end else begin
                clk_cnt <= clk_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/block_uart_streamer.sv
// Reads N decoded blocks from the RAM and frames them onto a UART line: A5, N, 6 bytes/block.
// Define STREAMER_CHECKSUM_EN to append an XOR checksum byte of everything after the sync byte.
module block_uart_streamer
    import block_uart_streamer_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 833,
    parameter int FETCH_TIMEOUT = 255,
    parameter int GAP_CYCLES    = 9600
) (
    input  logic                         clk_96MHz,
    input  logic                         rst_n,
    block_uart_streamer_if.master        ram,
    output logic                         uart_tx,
    output logic                         busy,
    output logic                         frame_done
);

`ifdef STREAMER_CHECKSUM_EN
    localparam logic [2:0] TRAIL_CNT0 = 3'd0;
`else
    localparam logic [2:0] TRAIL_CNT0 = 3'd1;
`endif

    state_t            state;
    logic [7:0]        n_lat;
    logic [7:0]        idx;
    logic [2:0]        byte_cnt;
    logic [15:0]       cnt;
    logic [WORD_W-1:0] word;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_fire;
    logic [7:0]        csum;

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = (byte_cnt == 3'd0) ? SYNC_BYTE : n_lat;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = word[WORD_W-1 -: 8];
            end
            ST_TRAIL: begin
                tx_valid = (byte_cnt == 3'd0);
                tx_data  = csum;
            end
            default: ;
        endcase
    end

    assign tx_fire = tx_valid && tx_ready;

`ifdef STREAMER_CHECKSUM_EN
    always_ff @(posedge clk_96MHz or negedge rst_n) begin
        if (!rst_n)
            csum <= 8'h00;
        else if (state == ST_IDLE)
            csum <= 8'h00;
        else if (tx_fire && state != ST_TRAIL && !(state == ST_HDR && byte_cnt == 3'd0))
            csum <= csum ^ tx_data;
    end
`else
    assign csum = 8'h00;
`endif

    always_ff @(posedge clk_96MHz or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= ST_IDLE;
            n_lat                   <= '0;
            idx                     <= '0;
            byte_cnt                <= '0;
            cnt                     <= '0;
            word                    <= '0;
            busy                    <= 1'b0;
            frame_done              <= 1'b0;
            ram.block_wanted_number <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: if (ram.avl_blocks_nb != 8'd0) begin
                    n_lat    <= ram.avl_blocks_nb;
                    idx      <= '0;
                    byte_cnt <= '0;
                    busy     <= 1'b1;
                    state    <= ST_HDR;
                end
                ST_HDR: if (tx_fire) begin
                    if (byte_cnt == 3'd1) begin
                        cnt                     <= '0;
                        ram.block_wanted_number <= idx;
                        state                   <= ST_FETCH;
                    end
                    byte_cnt <= byte_cnt + 3'd1;
                end
                // The cycle the index changes is skipped: data_ready may still refer to the old index.
                ST_FETCH: begin
                    cnt <= cnt + 16'd1;
                    if (cnt != 16'd0 && ram.data_ready) begin
                        word     <= block_to_word(ram.block_wanted);
                        byte_cnt <= '0;
                        state    <= ST_SEND;
                    end else if (cnt == 16'(FETCH_TIMEOUT)) begin
                        word     <= '1;
                        byte_cnt <= '0;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: if (tx_fire) begin
                    word <= {word[WORD_W-9:0], 8'h00};
                    if (byte_cnt == 3'(BYTES_PER_BLOCK - 1)) begin
                        idx <= idx + 8'd1;
                        cnt <= '0;
                        if (8'(idx + 8'd1) == n_lat) begin
                            byte_cnt <= TRAIL_CNT0;
                            state    <= ST_TRAIL;
                        end else begin
                            byte_cnt                <= '0;
                            ram.block_wanted_number <= idx + 8'd1;
                            state                   <= ST_FETCH;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + 3'd1;
                    end
                end
                // Frame ends once the transmitter reaches its final stop-bit cycle.
                ST_TRAIL: begin
                    if (tx_fire) begin
                        byte_cnt <= 3'd1;
                    end else if (byte_cnt == 3'd1 && tx_ready) begin
                        frame_done <= 1'b1;
                        cnt        <= '0;
                        state      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt == 16'(GAP_CYCLES - 1)) begin
                        busy                    <= 1'b0;
                        ram.block_wanted_number <= '0;
                        state                   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk_96MHz  (clk_96MHz),
        .rst_n      (rst_n),
        .byte_data  (tx_data),
        .byte_valid (tx_valid),
        .byte_ready (tx_ready),
        .tx         (uart_tx)
    );

endmodule
